clk_div_multi: RTL and testbench



---
 rtl/clk_div_multi.sv | 163 ++++++++++++++++
 tb/tb_clk_div_multi.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: per-channel tick pulse and square wave,
// runtime divisor writes that take effect on the next wrap. Optional PWM: CLKDIV_DUTY_EN.
module clk_div_multi #(
    parameter int          NUM_CH  = 4,
    parameter int          CH_W    = 2,
    parameter int          DIV_W   = 26,
    parameter int unsigned DEF_DIV = 33554432
) (
    input  logic              clk100MHz,
    input  logic              rst,
    input  logic              sync_clr,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [DIV_W-1:0]  wr_div,
`ifdef CLKDIV_DUTY_EN
    input  logic [DIV_W-1:0]  wr_duty,
`endif
    input  logic [CH_W-1:0]   rd_ch,
    output logic [DIV_W-1:0]  rd_div,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out
`ifdef CLKDIV_DUTY_EN
    ,
    output logic [NUM_CH-1:0] pwm_out
`endif
);

    localparam logic [DIV_W-1:0] DEF_V = DIV_W'(DEF_DIV);

    logic [DIV_W-1:0]  r_cnt [NUM_CH];
    logic [DIV_W-1:0]  r_act [NUM_CH];
    logic [DIV_W-1:0]  r_shd [NUM_CH];
    logic [NUM_CH-1:0] r_pend, r_tick, r_clk;

    logic [DIV_W-1:0]  w_cnt_nxt [NUM_CH];
    logic [DIV_W-1:0]  w_act_nxt [NUM_CH];
    logic [DIV_W-1:0]  w_shd_nxt [NUM_CH];
    logic [NUM_CH-1:0] w_pend_nxt, w_tick_nxt, w_clk_nxt;
    logic [NUM_CH-1:0] w_wr, w_wrap, w_load_new;

`ifdef CLKDIV_DUTY_EN
    localparam logic [DIV_W-1:0] DEF_DUTY = DIV_W'(DEF_DIV / 2);
    logic [DIV_W-1:0]  r_act_duty [NUM_CH];
    logic [DIV_W-1:0]  r_shd_duty [NUM_CH];
    logic [DIV_W-1:0]  w_act_duty_nxt [NUM_CH];
    logic [DIV_W-1:0]  w_shd_duty_nxt [NUM_CH];
    logic [NUM_CH-1:0] r_pwm, w_pwm_nxt;
`endif

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_wr[c]   = wr_en && (wr_ch == CH_W'(c));
            w_wrap[c] = (r_act[c] != '0) && (r_cnt[c] == r_act[c] - DIV_W'(1));
            // A write bypasses the shadow when the channel is idle or sits on its wrap edge.
            w_load_new[c] = w_wr[c] && ((r_act[c] == '0) || (w_wrap[c] && !sync_clr));

            w_cnt_nxt[c]  = r_cnt[c];
            w_act_nxt[c]  = r_act[c];
            w_shd_nxt[c]  = r_shd[c];
            w_pend_nxt[c] = r_pend[c];
            w_clk_nxt[c]  = r_clk[c];
            w_tick_nxt[c] = 1'b0;

            if (sync_clr) begin
                w_cnt_nxt[c] = '0;
                w_clk_nxt[c] = 1'b0;
            end else if (r_act[c] == '0) begin
                w_cnt_nxt[c] = '0;
            end else if (w_wrap[c]) begin
                w_cnt_nxt[c]  = '0;
                w_tick_nxt[c] = 1'b1;
                w_clk_nxt[c]  = ~r_clk[c];
                if (r_pend[c]) begin
                    w_act_nxt[c]  = r_shd[c];
                    w_pend_nxt[c] = 1'b0;
                end
            end else begin
                w_cnt_nxt[c] = r_cnt[c] + DIV_W'(1);
            end

            if (w_wr[c]) begin
                w_shd_nxt[c] = wr_div;
                if (w_load_new[c]) begin
                    w_act_nxt[c]  = wr_div;
                    w_pend_nxt[c] = 1'b0;
                end else begin
                    w_pend_nxt[c] = 1'b1;
                end
            end
        end
    end

`ifdef CLKDIV_DUTY_EN
    // Duty follows exactly the same shadow/activate path as the divisor.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_act_duty_nxt[c] = r_act_duty[c];
            w_shd_duty_nxt[c] = r_shd_duty[c];
            if (!sync_clr && w_wrap[c] && r_pend[c]) begin
                w_act_duty_nxt[c] = r_shd_duty[c];
            end
            if (w_wr[c]) begin
                w_shd_duty_nxt[c] = wr_duty;
                if (w_load_new[c]) begin
                    w_act_duty_nxt[c] = wr_duty;
                end
            end
            w_pwm_nxt[c] = (w_cnt_nxt[c] < w_act_duty_nxt[c]);
        end
    end
`endif

    always_ff @(posedge clk100MHz) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_cnt[c] <= '0;
                r_act[c] <= DEF_V;
                r_shd[c] <= DEF_V;
`ifdef CLKDIV_DUTY_EN
                r_act_duty[c] <= DEF_DUTY;
                r_shd_duty[c] <= DEF_DUTY;
`endif
            end
            r_pend <= '0;
            r_tick <= '0;
            r_clk  <= '0;
`ifdef CLKDIV_DUTY_EN
            r_pwm  <= '0;
`endif
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_act  <= w_act_nxt;
            r_shd  <= w_shd_nxt;
            r_pend <= w_pend_nxt;
            r_tick <= w_tick_nxt;
            r_clk  <= w_clk_nxt;
`ifdef CLKDIV_DUTY_EN
            r_act_duty <= w_act_duty_nxt;
            r_shd_duty <= w_shd_duty_nxt;
            r_pwm      <= w_pwm_nxt;
`endif
        end
    end

    // Unimplemented channel numbers read back as zero.
    always_comb begin
        rd_div = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_ch == CH_W'(c)) begin
                rd_div = r_act[c];
            end
        end
    end

    assign pending = r_pend;
    assign tick    = r_tick;
    assign clk_out = r_clk;
`ifdef CLKDIV_DUTY_EN
    assign pwm_out = r_pwm;
`endif

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi with DEF_DIV=4 and a 3-bit channel select so
// out-of-range channels can be exercised. PWM checks run when CLKDIV_DUTY_EN is defined.
module tb_clk_div_multi;
    localparam int NUM_CH  = 4;
    localparam int CH_W    = 3;
    localparam int DIV_W   = 26;
    localparam int DEF_DIV = 4;

    logic              clk = 1'b0;
    logic              rst, sync_clr, wr_en;
    logic [CH_W-1:0]   wr_ch, rd_ch;
    logic [DIV_W-1:0]  wr_div, rd_div;
    logic [NUM_CH-1:0] pending, tick, clk_out;
`ifdef CLKDIV_DUTY_EN
    logic [DIV_W-1:0]  wr_duty;
    logic [NUM_CH-1:0] pwm_out;
`endif

    always #5 clk = ~clk;

    clk_div_multi #(.NUM_CH(NUM_CH), .CH_W(CH_W), .DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) dut (
        .clk100MHz (clk),
        .rst       (rst),
        .sync_clr  (sync_clr),
        .wr_en     (wr_en),
        .wr_ch     (wr_ch),
        .wr_div    (wr_div),
`ifdef CLKDIV_DUTY_EN
        .wr_duty   (wr_duty),
        .pwm_out   (pwm_out),
`endif
        .rd_ch     (rd_ch),
        .rd_div    (rd_div),
        .pending   (pending),
        .tick      (tick),
        .clk_out   (clk_out)
    );

    typedef struct {
        logic              wr_en;
        logic [CH_W-1:0]   wr_ch;
        logic [DIV_W-1:0]  wr_div;
        logic [CH_W-1:0]   rd_ch;
        logic [NUM_CH-1:0] exp_tick;
        logic [NUM_CH-1:0] exp_clk;
        logic [NUM_CH-1:0] exp_pend;
        logic [DIV_W-1:0]  exp_rd;
    } vec_t;

    vec_t vecs[21];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   divs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wr(input int ch, input int div, input int duty);
        wr_en  = 1'b1;
        wr_ch  = CH_W'(ch);
        wr_div = DIV_W'(div);
`ifdef CLKDIV_DUTY_EN
        wr_duty = DIV_W'(duty);
`else
        if (duty < 0) $display("negative duty ignored");
`endif
        step();
        wr_en = 1'b0;
    endtask

    task automatic chk_rd(input int ch, input int exp);
        rd_ch = CH_W'(ch);
        #1;
        check($sformatf("rd_div[%0d]", ch), 32'(rd_div), 32'(exp));
    endtask

    initial begin
        rst = 1'b1; sync_clr = 1'b0; wr_en = 1'b0;
        wr_ch = '0; wr_div = '0; rd_ch = '0;
`ifdef CLKDIV_DUTY_EN
        wr_duty = '0;
`endif
        // Idle-running table: every channel at DEF_DIV=4, plus one ignored out-of-range write.
        for (int k = 1; k <= 20; k++) begin
            vecs[k-1].wr_en    = 1'b0;
            vecs[k-1].wr_ch    = '0;
            vecs[k-1].wr_div   = '0;
            vecs[k-1].rd_ch    = (k % 5 == 0) ? CH_W'(6) : CH_W'(k % 4);
            vecs[k-1].exp_rd   = (k % 5 == 0) ? DIV_W'(0) : DIV_W'(4);
            vecs[k-1].exp_tick = (k % 4 == 0) ? 4'hF : 4'h0;
            vecs[k-1].exp_clk  = ((k / 4) % 2 == 1) ? 4'hF : 4'h0;
            vecs[k-1].exp_pend = 4'h0;
        end
        vecs[20] = '{wr_en: 1'b1, wr_ch: 3'd5, wr_div: 26'd9, rd_ch: 3'd1,
                     exp_tick: 4'h0, exp_clk: 4'hF, exp_pend: 4'h0, exp_rd: 26'd4};

        step(); step();
        check("reset_tick", 32'(tick), 32'h0);
        check("reset_clk", 32'(clk_out), 32'h0);
        check("reset_pend", 32'(pending), 32'h0);
        for (int c = 0; c < NUM_CH; c++) chk_rd(c, DEF_DIV);
        rst = 1'b0;
        cyc = 0;

        for (int i = 0; i < 21; i++) begin
            wr_en  = vecs[i].wr_en;
            wr_ch  = vecs[i].wr_ch;
            wr_div = vecs[i].wr_div;
            rd_ch  = vecs[i].rd_ch;
            step();
            check("tbl_tick", 32'(tick), 32'(vecs[i].exp_tick));
            check("tbl_clk", 32'(clk_out), 32'(vecs[i].exp_clk));
            check("tbl_pend", 32'(pending), 32'(vecs[i].exp_pend));
            check("tbl_rd", 32'(rd_div), 32'(vecs[i].exp_rd));
        end
        wr_en = 1'b0;

        // Mid-period divisor change on channel 1: stays pending until the wrap at 24.
        step();
        wr(1, 10, 0);
        check("ch1_pend_set", 32'(pending), 32'h2);
        chk_rd(1, 4);
        step();
        check("ch1_wrap_tick", 32'(tick), 32'hF);
        check("ch1_pend_clr", 32'(pending), 32'h0);
        chk_rd(1, 10);
        while (cyc < 44) begin
            step();
            check("ch1_tick10", 32'(tick[1]), 32'(cyc == 34 || cyc == 44));
            check("ch0_tick4", 32'(tick[0]), 32'(cyc % 4 == 0));
        end

        // Channel 2 disabled after its wrap at 52 (clk_out[2]=1), then restarted at div 3.
        while (cyc < 48) step();
        wr(2, 0, 0);
        check("ch2_dis_pend", 32'(pending[2]), 32'h1);
        step(); step(); step();
        check("ch2_last_tick", 32'(tick[2]), 32'h1);
        check("ch2_last_clk", 32'(clk_out[2]), 32'h1);
        check("ch2_dis_pclr", 32'(pending[2]), 32'h0);
        chk_rd(2, 0);
        while (cyc < 58) begin
            step();
            check("ch2_off_tick", 32'(tick[2]), 32'h0);
            check("ch2_off_clk", 32'(clk_out[2]), 32'h1);
        end
        wr(2, 3, 0);
        check("ch2_en_pend", 32'(pending[2]), 32'h0);
        check("ch2_en_tick", 32'(tick[2]), 32'h0);
        chk_rd(2, 3);
        while (cyc < 65) begin
            step();
            check("ch2_div3_tick", 32'(tick[2]), 32'(cyc == 62 || cyc == 65));
            check("ch2_div3_clk", 32'(clk_out[2]), 32'(!(cyc >= 62 && cyc < 65)));
        end

        // Channel 3: write div 1 on its wrap edge at 68, then div 5 on a div-1 edge.
        step(); step();
        wr(3, 1, 0);
        check("ch3_d1_tick", 32'(tick[3]), 32'h1);
        check("ch3_d1_pend", 32'(pending[3]), 32'h0);
        check("ch3_d1_clk", 32'(clk_out[3]), 32'h1);
        chk_rd(3, 1);
        while (cyc < 74) begin
            step();
            check("ch3_d1_tick_run", 32'(tick[3]), 32'h1);
            check("ch3_d1_clk_run", 32'(clk_out[3]), 32'(cyc % 2 == 0));
        end
        wr(3, 5, 0);
        check("ch3_d5_tick", 32'(tick[3]), 32'h1);
        check("ch3_d5_clk", 32'(clk_out[3]), 32'h0);
        check("ch3_d5_pend", 32'(pending[3]), 32'h0);
        chk_rd(3, 5);
        while (cyc < 80) begin
            step();
            check("ch3_d5_run", 32'(tick[3]), 32'(cyc == 80));
        end

        // Back-to-back writes on channel 0: the last one wins at the wrap at 84.
        wr(0, 6, 0);
        wr(0, 7, 0);
        check("b2b_pend", 32'(pending[0]), 32'h1);
        chk_rd(0, 4);
        step();
        check("b2b_tick83", 32'(tick[0]), 32'h0);
        step();
        check("b2b_tick84", 32'(tick[0]), 32'h1);
        check("b2b_pclr", 32'(pending[0]), 32'h0);
        chk_rd(0, 7);
        while (cyc < 91) begin
            step();
            check("b2b_div7", 32'(tick[0]), 32'(cyc == 91));
        end

        // sync_clr with 3/5/7/5 running and a concurrent write to channel 3.
        wr(0, 3, 0);
        wr(1, 5, 0);
        wr(2, 7, 0);
        while (cyc < 110) step();
        check("pre_clr_pend", 32'(pending), 32'h0);
        chk_rd(0, 3); chk_rd(1, 5); chk_rd(2, 7); chk_rd(3, 5);
        sync_clr = 1'b1;
        wr(3, 6, 0);
        sync_clr = 1'b0;
        check("clr_tick", 32'(tick), 32'h0);
        check("clr_clk", 32'(clk_out), 32'h0);
        check("clr_pend", 32'(pending), 32'h8);
        chk_rd(0, 3); chk_rd(1, 5); chk_rd(2, 7); chk_rd(3, 5);
        divs[0] = 3; divs[1] = 5; divs[2] = 7; divs[3] = 5;
        for (int j = 1; j <= 8; j++) begin
            step();
            for (int c = 0; c < NUM_CH; c++) begin
                check($sformatf("align_tick%0d", c), 32'(tick[c]), 32'(j % divs[c] == 0));
                check($sformatf("align_clk%0d", c), 32'(clk_out[c]), 32'((j / divs[c]) % 2 == 1));
            end
        end
        check("clr_wr_pclr", 32'(pending), 32'h0);
        chk_rd(3, 6);
        for (int j = 9; j <= 11; j++) begin
            step();
            check("ch3_div6_tick", 32'(tick[3]), 32'(j == 11));
        end

        // Reset mid-period restores defaults.
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2_tick", 32'(tick), 32'h0);
        check("rst2_clk", 32'(clk_out), 32'h0);
        check("rst2_pend", 32'(pending), 32'h0);
        for (int c = 0; c < NUM_CH; c++) chk_rd(c, DEF_DIV);
        chk_rd(6, 0);
        cyc = 0;

`ifdef CLKDIV_DUTY_EN
        // div 10 / duty 3 activates at the wrap at 4; duty 0 at 24; duty 12 at 34.
        wr(0, 10, 3);
        while (cyc < 3) step();
        while (cyc < 23) begin
            step();
            check("pwm_duty3", 32'(pwm_out[0]), 32'(((cyc - 4) % 10) < 3));
        end
        wr(0, 10, 0);
        check("pwm_duty0", 32'(pwm_out[0]), 32'h0);
        while (cyc < 33) begin
            step();
            check("pwm_duty0_run", 32'(pwm_out[0]), 32'h0);
        end
        wr(0, 10, 12);
        check("pwm_duty12", 32'(pwm_out[0]), 32'h1);
        while (cyc < 43) begin
            step();
            check("pwm_duty12_run", 32'(pwm_out[0]), 32'h1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d got=running expected=finished", cyc);
        $fatal(1, "timeout");
    end
endmodule
